// File: rtl/xbus_dma_master.sv
// xbus bus-master DMA engine: moves a block of words between a local word port
// and dram, releasing the bus after every word so CPU cycles can interleave.
module xbus_dma_master #(
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [21:0]      base,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_pop,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             busreqout,
    input  logic             busgrantin,
    output logic [21:0]      addrout,
    output logic [31:0]      dataout,
    input  logic [31:0]      datain,
    output logic             reqout,
    output logic             writeout,
    input  logic             ackin,
    input  logic             decodein
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_REL, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [21:0]      addr;
    logic [CNT_W-1:0] cnt;
    logic             dir_r;
    logic             word_rdy;
    logic             abort_pend;
    logic [TMO_W-1:0] tmo;
    logic [31:0]      dataout_r;
    logic [31:0]      rd_data_r;
    logic             rd_valid_r;
    logic             err_r;

    logic arb_req;
    logic pop;
    logic ack_take;
    logic tmo_hit;

    // decode-in is informational only; it never gates a bus cycle
    logic unused_decode;
    assign unused_decode = decodein;

    // A write word must be in hand before the bus is requested for it
    always_comb begin
        arb_req   = (state == S_ARB) && (!dir_r || word_rdy || wr_valid);
        pop       = (state == S_ARB) && dir_r && !word_rdy && wr_valid;
        ack_take  = (state == S_REQ) && ackin;
        tmo_hit   = (state == S_REQ) && !ackin && (tmo == TMO_W'(TIMEOUT - 1));
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (count == '0) ? S_DONE : S_ARB;
            end
            S_ARB: begin
                if (!arb_req && abort)          state_nxt = S_DONE;
                else if (arb_req && busgrantin) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (ackin)        state_nxt = S_REL;
                else if (tmo_hit) state_nxt = S_DONE;
            end
            S_REL: begin
                state_nxt = (cnt == '0 || abort_pend || abort) ? S_DONE : S_ARB;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            cnt        <= '0;
            dir_r      <= 1'b0;
            word_rdy   <= 1'b0;
            abort_pend <= 1'b0;
            tmo        <= '0;
            dataout_r  <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_valid_r <= 1'b0;
            if (state == S_IDLE && start) begin
                addr       <= base;
                cnt        <= count;
                dir_r      <= dir;
                err_r      <= 1'b0;
                abort_pend <= 1'b0;
                word_rdy   <= 1'b0;
            end
            if (pop) begin
                dataout_r <= wr_data;
                word_rdy  <= 1'b1;
            end
            // An abort arriving mid-word is held until the word has finished
            if ((state == S_ARB || state == S_REQ || state == S_REL) && abort)
                abort_pend <= 1'b1;
            if (state == S_REQ) tmo <= tmo + 1'b1;
            else                tmo <= '0;
            if (ack_take) begin
                word_rdy <= 1'b0;
                addr     <= addr + 22'd1;
                cnt      <= cnt - 1'b1;
                if (!dir_r) begin
                    rd_data_r  <= datain;
                    rd_valid_r <= 1'b1;
                end
            end
            if (tmo_hit) begin
                err_r    <= 1'b1;
                word_rdy <= 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_r;
    assign wr_pop    = pop;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign busreqout = arb_req || (state == S_REQ);
    assign reqout    = (state == S_REQ);
    assign writeout  = (state == S_REQ) && dir_r;
    assign addrout   = addr;
    assign dataout   = dataout_r;

endmodule

// File: tb/tb_xbus_dma_master.sv
// Scoreboard bench for xbus_dma_master: a randomized bus slave/arbiter model
// drives the DUT while a monitor compares every bus cycle and local-port event.
module tb_xbus_dma_master;
    localparam int TIMEOUT = 31;
    localparam int CNT_W   = 16;
    localparam int NEVER   = 255;

    logic             clk = 1'b0;
    logic             reset, start, dir, abort;
    logic [21:0]      base;
    logic [CNT_W-1:0] count;
    logic             busy, done, err;
    logic [31:0]      wr_data;
    logic             wr_valid, wr_pop;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             busreqout, busgrantin;
    logic [21:0]      addrout;
    logic [31:0]      dataout, datain;
    logic             reqout, writeout, ackin, decodein;

    typedef struct {
        logic [21:0] addr;
        logic        we;
        logic [31:0] data;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    logic        exp_done[$];
    logic [31:0] wr_q[$];

    int checks = 0, passed = 0;
    int cyc = 0;
    int gd = 0, ad = 0;
    bit wr_toggle = 0, mon_en = 0;
    int acks, pops, reqcyc, arbwait, done_cyc;
    bit done_seen, any_busreq, gseen, prev_req, rel_pend;
    int gcnt = 0, acnt = 0;

    xbus_dma_master #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .base(base),
        .count(count), .abort(abort), .busy(busy), .done(done), .err(err),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .busreqout(busreqout),
        .busgrantin(busgrantin), .addrout(addrout), .dataout(dataout),
        .datain(datain), .reqout(reqout), .writeout(writeout), .ackin(ackin),
        .decodein(decodein)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign decodein = reqout;

    // dram contents as seen by the bench: a fixed function of the address
    function automatic logic [31:0] memword(input logic [21:0] a);
        return {a[9:0], a} ^ 32'hC3A5_96E1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Local write source plus bus arbiter/slave with programmable delays
    initial begin
        wr_valid = 0; wr_data = 0; busgrantin = 0; ackin = 0; datain = 0;
        forever begin
            @(posedge clk); #1;
            wr_valid = (wr_q.size() > 0) && (!wr_toggle || ($urandom_range(1, 0) == 1));
            wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
            #1;
            if (busreqout) begin
                if (gcnt >= gd) busgrantin = 1;
                else begin busgrantin = 0; gcnt++; end
            end else begin
                busgrantin = 0; gcnt = 0;
            end
            if (reqout && ad != NEVER && acnt >= ad) begin
                ackin = 1; datain = memword(addrout);
            end else begin
                ackin = 0; datain = $urandom;
                if (reqout) acnt++; else acnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (rel_pend) begin
                chk("release_gap", {busreqout, reqout}, 2'b00);
                rel_pend = 0;
            end
            if (busreqout) any_busreq = 1;
            if (busreqout && !busgrantin && !reqout) arbwait++;
            if (reqout && !prev_req) chk("grant_before_req", gseen, 1);
            if (reqout) begin
                reqcyc++;
                if (exp_bus.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    chk("addrout", addrout, exp_bus[0].addr);
                    chk("writeout", writeout, exp_bus[0].we);
                    if (exp_bus[0].we) chk("dataout", dataout, exp_bus[0].data);
                    if (ackin) begin
                        exp_bus.delete(0); acks++; rel_pend = 1;
                    end
                end
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("unexpected_rd_valid", 1, 0);
                else begin chk("rd_data", rd_data, exp_rd[0]); exp_rd.delete(0); end
            end
            if (wr_pop) begin
                pops++;
                if (wr_q.size() > 0) wr_q.delete(0);
                else chk("unexpected_wr_pop", 1, 0);
            end
            if (done) begin
                done_seen = 1; done_cyc = cyc;
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin chk("done_err", err, exp_done[0]); exp_done.delete(0); end
            end
            if (!busreqout) gseen = 0;
            else if (busgrantin) gseen = 1;
            prev_req = reqout;
        end
    end

    task automatic flush();
        exp_bus.delete(); exp_rd.delete(); exp_done.delete(); wr_q.delete();
    endtask

    task automatic run_xfer(input string name, input logic d, input logic [21:0] b,
                            input int n, input int g, input int a, input int abort_at,
                            input bit junk_start, input int exp_lat);
        int   ncomp, nattempt, t0, k;
        bit   tmo_exp, aborted;
        bus_t e;
        aborted  = 0;
        tmo_exp  = (n > 0) && (a == NEVER);
        ncomp    = tmo_exp ? 0 : ((abort_at > 0 && abort_at < n) ? abort_at : n);
        nattempt = tmo_exp ? 1 : ncomp;
        for (int i = 0; i < nattempt; i++) begin
            e.addr = b + 22'(i); e.we = d; e.data = 32'h0;
            if (d) begin e.data = $urandom; wr_q.push_back(e.data); end
            else if (i < ncomp) exp_rd.push_back(memword(e.addr));
            exp_bus.push_back(e);
        end
        exp_done.push_back(tmo_exp);
        gd = g; ad = a;
        acks = 0; pops = 0; reqcyc = 0; arbwait = 0; done_seen = 0; any_busreq = 0;
        @(posedge clk); #1;
        dir = d; base = b; count = CNT_W'(n); start = 1; t0 = cyc;
        @(posedge clk); #1;
        start = 0;
        k = 0;
        while (!done_seen && k < 3000) begin
            @(negedge clk);
            if (k == 0) chk({name, "_err_clear"}, err, 0);
            @(posedge clk); #1;
            start = junk_start && (k == 0);
            if (start) begin dir = ~d; base = 22'h155555; count = 7; end
            abort = (abort_at > 0) && !aborted && (acks == abort_at - 1) && reqout;
            if (abort) aborted = 1;
            k++;
        end
        abort = 0; start = 0;
        if (!done_seen) begin
            chk({name, "_done_arrived"}, 0, 1);
            reset = 1; @(posedge clk); #1; reset = 0;
        end else begin
            @(negedge clk);
            chk({name, "_busy_after_done"}, busy, 0);
            if (exp_lat >= 0) chk({name, "_latency"}, done_cyc - t0, exp_lat);
            chk({name, "_bus_left"}, exp_bus.size(), tmo_exp ? 1 : 0);
            chk({name, "_rd_left"}, exp_rd.size(), 0);
            chk({name, "_pops"}, pops, d ? nattempt : 0);
            chk({name, "_acks"}, acks, ncomp);
            if (tmo_exp) begin
                chk({name, "_req_cycles"}, reqcyc, TIMEOUT);
                chk({name, "_err_sticky"}, err, 1);
            end
        end
        flush();
    endtask

    initial begin
        int k, dn;
        reset = 1; start = 0; dir = 0; base = 0; count = 0; abort = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, done, err, wr_pop, rd_valid, busreqout, reqout, writeout}, 0);
        chk("reset_addr", addrout, 0);
        chk("reset_data", {dataout, rd_data}, 0);
        @(posedge clk); #1;
        reset = 0; mon_en = 1;

        run_xfer("read4", 0, 22'o1000, 4, 0, 0, 0, 1, 13);
        wr_toggle = 1;
        run_xfer("write3", 1, 22'o2000, 3, 0, 0, 0, 0, -1);
        wr_toggle = 0;
        run_xfer("grant_wait", 0, 22'o3000, 1, 20, 0, 0, 0, 24);
        chk("grant_wait_cycles", arbwait, 20);
        run_xfer("no_ack", 0, 22'o4000, 2, 0, NEVER, 0, 0, 33);
        run_xfer("wrap", 0, 22'o17777777, 2, 0, 0, 0, 0, 7);
        run_xfer("zero", 0, 22'o100, 0, 0, 0, 0, 0, 1);
        chk("zero_no_busreq", any_busreq, 0);
        run_xfer("abort", 0, 22'o5000, 5, 0, 2, 2, 0, -1);

        // reset while a word is on the bus
        mon_en = 0; gd = 0; ad = NEVER;
        @(posedge clk); #1;
        dir = 0; base = 22'o6000; count = 3; start = 1;
        @(posedge clk); #1;
        start = 0;
        k = 0;
        while (!reqout && k < 50) begin @(posedge clk); #1; k++; end
        chk("rst_reached_req", reqout, 1);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ctrl", {busy, done, err, wr_pop, rd_valid, busreqout, reqout, writeout}, 0);
        chk("rst_mid_addr", addrout, 0);
        chk("rst_mid_data", {dataout, rd_data}, 0);
        @(posedge clk); #1;
        reset = 0;
        dn = 0;
        repeat (5) begin @(negedge clk); if (done) dn++; end
        chk("rst_no_done", dn, 0);
        flush();
        prev_req = 0; gseen = 0; rel_pend = 0; ad = 0;
        mon_en = 1;

        for (int i = 0; i < 8; i++) begin
            wr_toggle = $urandom_range(1, 0);
            run_xfer("rand", 1'($urandom_range(1, 0)), 22'($urandom),
                     $urandom_range(6, 1), $urandom_range(3, 0), $urandom_range(3, 0),
                     0, 1'($urandom_range(1, 0)), -1);
        end
        wr_toggle = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
